// File: rtl/stopwatch_ctrl_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | stopwatch_ctrl_if                                                       |
// | Bundles the button pulses, the live stopwatch value and the controller |
// | outputs exchanged between stopwatch_ctrl and its environment.          |
// |                                                                        |
// | master : drives btn_start/btn_clear/btn_set/btn_inc and live_bcd,      |
// |          observes the controller outputs.                              |
// | slave  : the controller; consumes the buttons and live_bcd, drives     |
// |          count_enable, load_value_enable, load_bcd, disp_bcd,          |
// |          digit_sel, mode and full.                                     |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
interface stopwatch_ctrl_if;
  logic        btn_start;
  logic        btn_clear;
  logic        btn_set;
  logic        btn_inc;
  logic [15:0] live_bcd;
  logic        count_enable;
  logic        load_value_enable;
  logic [15:0] load_bcd;
  logic [15:0] disp_bcd;
  logic [1:0]  digit_sel;
  logic [1:0]  mode;
  logic        full;

  modport master (
    output btn_start, btn_clear, btn_set, btn_inc, live_bcd,
    input  count_enable, load_value_enable, load_bcd, disp_bcd,
           digit_sel, mode, full
  );

  modport slave (
    input  btn_start, btn_clear, btn_set, btn_inc, live_bcd,
    output count_enable, load_value_enable, load_bcd, disp_bcd,
           digit_sel, mode, full
  );
endinterface
`default_nettype wire

// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | stopwatch_ctrl                                                          |
// | Mode controller for an mm:ss BCD stopwatch: run/pause, lap hold,       |
// | clear, and a four-digit SET editor that loads a new value.             |
// |                                                                        |
// | Ports:                                                                 |
// |   clk  - single clock, rising edge                                     |
// |   rst  - asynchronous active-high reset                                |
// |   bus  - stopwatch_ctrl_if.slave: button pulses and live_bcd in;       |
// |          count_enable, load_value_enable, load_bcd, disp_bcd,          |
// |          digit_sel, mode, full out                                     |
// | Parameter TICK_DIV: clk cycles per counted second (>= 2).              |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module stopwatch_ctrl #(
  parameter int unsigned TICK_DIV = 100000000
) (
  input logic             clk,
  input logic             rst,
  stopwatch_ctrl_if.slave bus
);

  localparam int unsigned DIV_W = $clog2(TICK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    SET   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             lap_held_q, lap_held_d;
  logic [15:0]      lap_q, lap_d;
  logic [15:0]      edit_q, edit_d;
  logic [1:0]       digit_q, digit_d;
  logic             load_en_q, load_en_d;
  logic [15:0]      load_val_q, load_val_d;

  logic             full;
  logic [3:0]       cur_digit;
  logic [3:0]       digit_max;

  // Tens digits (sec1, min1) wrap after 5, units digits after 9.
  function automatic logic [3:0] digit_inc(input logic [3:0] d, input logic [3:0] max);
    return (d >= max) ? 4'd0 : d + 4'd1;
  endfunction

  assign full      = (bus.live_bcd == 16'h5959);
  assign cur_digit = edit_q[{digit_q, 2'b00} +: 4];
  assign digit_max = digit_q[0] ? 4'd5 : 4'd9;

  always_comb begin
    state_d    = state_q;
    div_d      = '0;
    lap_held_d = lap_held_q;
    lap_d      = lap_q;
    edit_d     = edit_q;
    digit_d    = digit_q;
    load_en_d  = 1'b0;
    load_val_d = '0;

    // Each branch is an if/else-if chain in button priority order, so only
    // the highest-priority pulse is considered even when it is ignored.
    case (state_q)
      IDLE: begin
        if (bus.btn_clear) begin
          load_en_d = 1'b1;
        end else if (bus.btn_start) begin
          state_d = RUN;
        end else if (bus.btn_set) begin
          state_d = SET;
          digit_d = 2'd0;
          edit_d  = bus.live_bcd;
        end
      end

      RUN: begin
        if (bus.btn_clear) begin
          if (lap_held_q) begin
            lap_held_d = 1'b0;
            lap_d      = '0;
          end else begin
            lap_held_d = 1'b1;
            lap_d      = bus.live_bcd;
          end
        end else if (bus.btn_start) begin
          state_d = PAUSE;
        end
        // Reaching 59:59 stops the watch regardless of buttons.
        if (full) begin
          state_d = PAUSE;
        end
        // Divider only advances while staying in RUN, so it is zero on the
        // first RUN cycle and whenever RUN is left.
        if (state_d == RUN) begin
          div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
        end
      end

      PAUSE: begin
        if (bus.btn_clear) begin
          load_en_d  = 1'b1;
          lap_held_d = 1'b0;
          lap_d      = '0;
          state_d    = IDLE;
        end else if (bus.btn_start) begin
          if (!full) begin
            state_d = RUN;
          end
        end
      end

      SET: begin
        if (bus.btn_clear) begin
          state_d = IDLE;
          digit_d = 2'd0;
        end else if (bus.btn_start) begin
          state_d = SET;
        end else if (bus.btn_set) begin
          if (digit_q == 2'd3) begin
            load_en_d  = 1'b1;
            load_val_d = edit_q;
            state_d    = IDLE;
            digit_d    = 2'd0;
          end else begin
            digit_d = digit_q + 2'd1;
          end
        end else if (bus.btn_inc) begin
          edit_d[{digit_q, 2'b00} +: 4] = digit_inc(cur_digit, digit_max);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      div_q      <= '0;
      lap_held_q <= 1'b0;
      lap_q      <= '0;
      edit_q     <= '0;
      digit_q    <= 2'd0;
      load_en_q  <= 1'b0;
      load_val_q <= '0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      lap_held_q <= lap_held_d;
      lap_q      <= lap_d;
      edit_q     <= edit_d;
      digit_q    <= digit_d;
      load_en_q  <= load_en_d;
      load_val_q <= load_val_d;
    end
  end

  assign bus.count_enable      = (state_q == RUN) && (div_q == DIV_LAST) && !full;
  assign bus.load_value_enable = load_en_q;
  assign bus.load_bcd          = load_val_q;
  assign bus.disp_bcd          = (state_q == SET) ? edit_q :
                                 lap_held_q       ? lap_q  : bus.live_bcd;
  assign bus.digit_sel         = digit_q;
  assign bus.mode              = state_q;
  assign bus.full              = full;

endmodule
`default_nettype wire
